tm1640_rx: RTL and testbench
============================

TM1640_RX -- requirements
Module: tm1640_rx

Interface
REQ-001 Parameter CLK_FREQ, default 10_000_000, system clock frequency in Hz.
REQ-002 Parameter TIMEOUT_US, default 1000, maximum idle time inside a frame before abort.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 tm_clk  input  1  TM1640 serial clock, asynchronous to clk.
REQ-006 tm_din  input  1  TM1640 serial data, asynchronous to clk.
REQ-007 led_data  output  72  committed segment bytes; digit n at bits [8n+7:8n], n = 0..8.
REQ-008 level  output  3  committed brightness level.
REQ-009 on  output  1  committed display-on flag.
REQ-010 frame_done  output  1  one-cycle pulse on every error-free frame end.
REQ-011 err  output  1  one-cycle pulse on every protocol error.
REQ-012 busy  output  1  high from start condition until frame end or abort.

Function
REQ-013 tm_clk and tm_din SHALL each pass a 2-FF synchronizer; all decoding uses the synchronized signals only.
REQ-014 Start condition: synced din falls while synced clk is high; stop condition: synced din rises while synced clk is high.
REQ-015 Data bits SHALL be sampled on the synced tm_clk rising edge, LSB first; 8 bits form one byte.
REQ-016 FSM states: IDLE, CMD, DATA, SKIP; reset state IDLE.
REQ-017 IDLE -> CMD on start; bit counter cleared; busy = 1.
REQ-018 CMD, first byte 01xx_xMxx (data command): store M (1 = fixed address, 0 = auto-increment) in a pending register; go to SKIP.
REQ-019 CMD, byte 11xx_aaaa (address command): address pointer = aaaa; go to DATA.
REQ-020 CMD, byte 10xx_oLLL (display control): pending on = o, pending level = LLL; go to SKIP.
REQ-021 CMD, byte 00xx_xxxx: err pulse; go to SKIP; frame SHALL commit nothing.
REQ-022 In DATA, each complete byte SHALL be written to shadow digit[ptr] when ptr <= 8; when ptr >= 9 the byte is discarded silently.
REQ-023 In auto mode ptr increments after each byte, saturating at 15; in fixed mode ptr is unchanged.
REQ-024 Bytes received in SKIP are ignored.
REQ-025 On stop with bit counter = 0 and no error, the frame's shadow digits, mode, on and level SHALL commit to outputs in one clk cycle; frame_done pulses that cycle; busy drops that cycle.
REQ-026 Commit latency: outputs change at most 4 clk cycles after the raw tm_din rising edge forming the stop.
REQ-027 Stop with bit counter != 0 (partial byte): err pulse; no commit; -> IDLE.
REQ-028 Start while busy (restart): err pulse; partial frame discarded; -> CMD with a fresh frame.
REQ-029 No synced tm_clk edge for CLK_FREQ*TIMEOUT_US/1_000_000 cycles while busy: err pulse; no commit; -> IDLE.
REQ-030 Address bytes not written in a frame SHALL keep their previously committed values.
REQ-031 frame_done and err SHALL never assert in the same cycle.

Reset
REQ-032 While rst = 0: led_data = 0, level = 0, on = 0, mode = auto, frame_done = 0, err = 0, busy = 0, FSM = IDLE, synchronizers = 1.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no commit and no err pulse.
REQ-034 After rst returns to 1, a frame already in progress on the lines SHALL be ignored until the next start condition.

Verification
REQ-035 Frame 0x40, then frame 0xC0 plus bytes 0x3F,0x06,...,0x6F (9 bytes) -> led_data[7:0] = 0x3F, led_data[71:64] = 0x6F, one frame_done per frame.
REQ-036 Frame 0x8C -> on = 1, level = 4, led_data unchanged, frame_done pulses.
REQ-037 Frame 0x44, then 0xC3 plus 0x11,0x22 -> digit 3 = 0x22, other digits unchanged.
REQ-038 0xCA plus 3 bytes in auto mode -> no led_data change, frame_done pulses, err stays 0.
REQ-039 Stop after 5 bits of a data byte -> err pulses once, led_data unchanged; restart mid-byte -> err pulses, next frame decodes correctly.
REQ-040 tm_clk held high mid-frame beyond the timeout -> err pulses once, busy = 0; rst = 0 mid-frame -> all outputs 0, no err.

Source files
------------

// File: rtl/tm1640_rx.sv
// tm1640_rx: passive TM1640 bus decoder that commits segment, brightness and on/off state on clean frame ends.
module tm1640_rx #(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int TIMEOUT_US = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tm_clk,
    input  logic        tm_din,
    output logic [71:0] led_data,
    output logic [2:0]  level,
    output logic        on,
    output logic        frame_done,
    output logic        err,
    output logic        busy
);
    localparam longint TO_CYC = longint'(CLK_FREQ) * longint'(TIMEOUT_US) / 64'd1_000_000;
    localparam int     TO_W   = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, SKIP} state_t;
    state_t r_state, w_next;

    logic [1:0]      r_clk_s, r_din_s;
    logic            r_clk_q, r_din_q;
    logic            r_bit, r_pend;
    logic [2:0]      r_bit_cnt;
    logic [6:0]      r_sh;
    logic [TO_W-1:0] r_to_cnt;
    logic [3:0]      r_ptr;
    logic            r_ferr;
    logic            r_pmode, r_pon, r_mode, r_on;
    logic [2:0]      r_plevel, r_level;
    logic [8:0][7:0] r_shadow, r_led;
    logic            r_done, r_err;

    logic       w_clk, w_din, w_rise, w_fall, w_edge, w_start, w_stop, w_tout;
    logic       w_acc, w_byte_done, w_clear;
    logic [7:0] w_byte;
    logic       w_new_frame, w_commit, w_err, w_fault, w_wr, w_ptr_set, w_ptr_inc, w_pmode_ld, w_pdisp_ld;

    assign w_clk   = r_clk_s[1];
    assign w_din   = r_din_s[1];
    assign w_rise  = w_clk & ~r_clk_q;
    assign w_fall  = ~w_clk & r_clk_q;
    assign w_edge  = w_clk ^ r_clk_q;
    assign w_start = w_clk & r_din_q & ~w_din;
    assign w_stop  = w_clk & ~r_din_q & w_din;
    assign w_tout  = (r_state != IDLE) && !w_edge && (r_to_cnt == TO_W'(TO_CYC - 1));
    // A bit sampled on the rising edge is only accepted at the following falling edge,
    // so the clock pulse that frames a start/stop never counts as data.
    assign w_acc       = w_fall & r_pend;
    assign w_byte_done = w_acc && (r_bit_cnt == 3'd7);
    assign w_byte      = {r_bit, r_sh};
    assign w_clear     = w_new_frame || (w_next == IDLE);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_new_frame = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        w_fault     = 1'b0;
        w_wr        = 1'b0;
        w_ptr_set   = 1'b0;
        w_ptr_inc   = 1'b0;
        w_pmode_ld  = 1'b0;
        w_pdisp_ld  = 1'b0;
        if (w_start) begin
            w_new_frame = 1'b1;
            w_err       = (r_state != IDLE);
            w_next      = CMD;
        end else if (r_state != IDLE) begin
            if (w_stop) begin
                w_next   = IDLE;
                w_err    = (r_bit_cnt != 3'd0);
                w_commit = (r_bit_cnt == 3'd0) && !r_ferr;
            end else if (w_tout) begin
                w_err  = 1'b1;
                w_next = IDLE;
            end else if (w_byte_done) begin
                case (r_state)
                    CMD: begin
                        case (w_byte[7:6])
                            2'b01: begin
                                w_pmode_ld = 1'b1;
                                w_next     = SKIP;
                            end
                            2'b11: begin
                                w_ptr_set = 1'b1;
                                w_next    = DATA;
                            end
                            2'b10: begin
                                w_pdisp_ld = 1'b1;
                                w_next     = SKIP;
                            end
                            default: begin
                                w_err   = 1'b1;
                                w_fault = 1'b1;
                                w_next  = SKIP;
                            end
                        endcase
                    end
                    DATA: begin
                        w_wr      = (r_ptr <= 4'd8);
                        w_ptr_inc = !r_mode && (r_ptr != 4'hF);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_s   <= 2'b11;
            r_din_s   <= 2'b11;
            r_clk_q   <= 1'b1;
            r_din_q   <= 1'b1;
            r_bit     <= 1'b0;
            r_pend    <= 1'b0;
            r_bit_cnt <= 3'd0;
            r_sh      <= 7'd0;
            r_to_cnt  <= '0;
            r_ptr     <= 4'd0;
            r_ferr    <= 1'b0;
            r_pmode   <= 1'b0;
            r_pon     <= 1'b0;
            r_plevel  <= 3'd0;
            r_shadow  <= '0;
            r_led     <= '0;
            r_mode    <= 1'b0;
            r_on      <= 1'b0;
            r_level   <= 3'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_clk_s   <= {r_clk_s[0], tm_clk};
            r_din_s   <= {r_din_s[0], tm_din};
            r_clk_q   <= w_clk;
            r_din_q   <= w_din;
            r_bit     <= w_rise ? w_din : r_bit;
            r_pend    <= w_clear ? 1'b0 : w_rise ? 1'b1 : w_fall ? 1'b0 : r_pend;
            r_bit_cnt <= w_clear ? 3'd0 : w_acc ? r_bit_cnt + 3'd1 : r_bit_cnt;
            r_sh      <= w_acc ? {r_bit, r_sh[6:1]} : r_sh;
            r_to_cnt  <= (w_clear || w_edge) ? '0 : r_to_cnt + TO_W'(1);
            r_ptr     <= w_ptr_set ? w_byte[3:0] : w_ptr_inc ? r_ptr + 4'd1 : r_ptr;
            r_ferr    <= w_new_frame ? 1'b0 : w_fault ? 1'b1 : r_ferr;
            r_pmode   <= w_new_frame ? r_mode : w_pmode_ld ? w_byte[2] : r_pmode;
            r_pon     <= w_new_frame ? r_on : w_pdisp_ld ? w_byte[3] : r_pon;
            r_plevel  <= w_new_frame ? r_level : w_pdisp_ld ? w_byte[2:0] : r_plevel;
            if (w_new_frame) r_shadow <= r_led;
            else if (w_wr) r_shadow[r_ptr] <= w_byte;
            if (w_commit) begin
                r_led   <= r_shadow;
                r_mode  <= r_pmode;
                r_on    <= r_pon;
                r_level <= r_plevel;
            end
            r_done <= w_commit;
            r_err  <= w_err;
        end
    end

    assign led_data   = r_led;
    assign level      = r_level;
    assign on         = r_on;
    assign frame_done = r_done;
    assign err        = r_err;
    assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_tm1640_rx.sv
// tb_tm1640_rx: directed TM1640 frames against hand-computed register contents and pulse counts.
module tb_tm1640_rx;
    logic        clk = 1'b0;
    logic        rst, tm_clk, tm_din;
    logic [71:0] led_data;
    logic [2:0]  level;
    logic        on, frame_done, err, busy;
    int checks = 0, errors = 0;
    int n_done = 0, n_err = 0, n_both = 0;

    localparam logic [71:0] E1 = 72'h6F_07_7D_6D_66_4F_5B_06_3F;
    localparam logic [71:0] E2 = 72'h6F_07_7D_6D_66_22_5B_06_3F;
    localparam logic [71:0] E3 = 72'h6F_07_7D_5A_66_22_5B_06_3F;

    tm1640_rx #(.CLK_FREQ(10_000_000), .TIMEOUT_US(20)) dut (
        .clk(clk), .rst(rst), .tm_clk(tm_clk), .tm_din(tm_din),
        .led_data(led_data), .level(level), .on(on),
        .frame_done(frame_done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (err) n_err++;
        if (frame_done && err) n_both++;
    end

    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic tm_start();
        tm_din = 1'b0;
        tick();
        tm_clk = 1'b0;
        tick();
    endtask

    task automatic tm_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            tm_din = b[i];
            tick();
            tm_clk = 1'b1;
            tick();
            tm_clk = 1'b0;
            tick();
        end
    endtask

    task automatic tm_byte(input logic [7:0] b);
        tm_bits(b, 8);
    endtask

    task automatic tm_stop();
        tm_din = 1'b0;
        tick();
        tm_clk = 1'b1;
        tick();
        tm_din = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] digits [9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h6F};
        rst = 1'b0; tm_clk = 1'b1; tm_din = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_led", led_data, 72'd0);
        check("rst_level", 72'(level), 72'd0);
        check("rst_on", 72'(on), 72'd0);
        check("rst_busy", 72'(busy), 72'd0);
        check("rst_done", 72'(frame_done), 72'd0);
        check("rst_err", 72'(err), 72'd0);
        rst = 1'b1;
        tick();

        tm_start(); tm_byte(8'h40); tm_stop();
        check("cmd40_led", led_data, 72'd0);
        check("cmd40_done", 72'(n_done), 72'd1);

        tm_start();
        check("busy_hi", 72'(busy), 72'd1);
        tm_byte(8'hC0);
        for (int i = 0; i < 9; i++) tm_byte(digits[i]);
        tm_stop();
        check("auto9_busy", 72'(busy), 72'd0);
        check("auto9_led", led_data, E1);
        check("auto9_done", 72'(n_done), 72'd2);

        tm_start(); tm_byte(8'h8C); tm_stop();
        check("disp_on", 72'(on), 72'd1);
        check("disp_level", 72'(level), 72'd4);
        check("disp_led", led_data, E1);
        check("disp_done", 72'(n_done), 72'd3);

        tm_start(); tm_byte(8'h44); tm_stop();
        tm_start(); tm_byte(8'hC3); tm_byte(8'h11); tm_byte(8'h22); tm_stop();
        check("fixed_led", led_data, E2);
        check("fixed_done", 72'(n_done), 72'd5);

        tm_start(); tm_byte(8'h40); tm_stop();
        tm_start(); tm_byte(8'hCA); tm_byte(8'hAA); tm_byte(8'hBB); tm_byte(8'hCC); tm_stop();
        check("oob_led", led_data, E2);
        check("oob_done", 72'(n_done), 72'd7);
        check("oob_err", 72'(n_err), 72'd0);

        tm_start(); tm_byte(8'hC0); tm_byte(8'h12); tm_bits(8'h1F, 5); tm_stop();
        check("part_err", 72'(n_err), 72'd1);
        check("part_led", led_data, E2);
        check("part_done", 72'(n_done), 72'd7);

        tm_start(); tm_byte(8'hC0); tm_bits(8'h05, 3);
        tm_din = 1'b1; tick();
        tm_clk = 1'b1; tick();
        tm_start();
        check("restart_err", 72'(n_err), 72'd2);
        check("restart_busy", 72'(busy), 72'd1);
        tm_byte(8'hC5); tm_byte(8'h5A); tm_stop();
        check("restart_led", led_data, E3);
        check("restart_done", 72'(n_done), 72'd8);
        check("restart_err2", 72'(n_err), 72'd2);

        tm_start(); tm_byte(8'hC0); tm_byte(8'h77);
        tm_clk = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("tout_err", 72'(n_err), 72'd3);
        check("tout_busy", 72'(busy), 72'd0);
        check("tout_led", led_data, E3);
        check("tout_done", 72'(n_done), 72'd8);
        tm_din = 1'b1; tick();
        check("tout_stop_ign", 72'(n_err), 72'd3);

        tm_start(); tm_byte(8'hC0); tm_byte(8'h99);
        rst = 1'b0; tick();
        check("mrst_led", led_data, 72'd0);
        check("mrst_on", 72'(on), 72'd0);
        check("mrst_level", 72'(level), 72'd0);
        check("mrst_busy", 72'(busy), 72'd0);
        check("mrst_err", 72'(n_err), 72'd3);
        rst = 1'b1; tick();
        tm_byte(8'h88); tm_stop();
        check("post_rst_done", 72'(n_done), 72'd8);
        check("post_rst_led", led_data, 72'd0);
        check("post_rst_err", 72'(n_err), 72'd3);

        tm_start(); tm_byte(8'hC1); tm_byte(8'hAB); tm_stop();
        check("final_led", led_data, 72'h00_00_00_00_00_00_00_AB_00);
        check("final_done", 72'(n_done), 72'd9);
        check("final_err", 72'(n_err), 72'd3);
        check("never_both", 72'(n_both), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
